mdu_unit: RTL

- Iterative multiply/divide unit in the EX stage, beside the ALU.
- Handles MULT, MULTU, DIV, DIVU, MTHI and MTLO, and owns the HI/LO registers.
- Generalises the funct decoding done by alu_control, adding multi-cycle sequencing and a busy/done handshake that the hazard unit uses for stalls.
- The operand width is parametrised.

---
 rtl/mdu_unit_pkg.sv | 43 ++++
 rtl/mdu_div_step.sv | 29 ++
 rtl/mdu_unit.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/mdu_unit_pkg.sv
// Shared codes for the multiply/divide unit: funct encodings, FSM state encodings and
// a leading-zero helper used by the optional early-termination path.
package mdu_unit_pkg;

    localparam int unsigned CODE_FUNCT_MFHI  = 'h10;
    localparam int unsigned CODE_FUNCT_MTHI  = 'h11;
    localparam int unsigned CODE_FUNCT_MFLO  = 'h12;
    localparam int unsigned CODE_FUNCT_MTLO  = 'h13;
    localparam int unsigned CODE_FUNCT_MULT  = 'h18;
    localparam int unsigned CODE_FUNCT_MULTU = 'h19;
    localparam int unsigned CODE_FUNCT_DIV   = 'h1A;
    localparam int unsigned CODE_FUNCT_DIVU  = 'h1B;

    localparam logic [2:0] CODE_MDU_ST_IDLE = 3'd0;
    localparam logic [2:0] CODE_MDU_ST_MUL  = 3'd1;
    localparam logic [2:0] CODE_MDU_ST_DIV  = 3'd2;
    localparam logic [2:0] CODE_MDU_ST_FIX  = 3'd3;
    localparam logic [2:0] CODE_MDU_ST_DONE = 3'd4;

    typedef enum logic [2:0] {
        StIdle = CODE_MDU_ST_IDLE,
        StMul  = CODE_MDU_ST_MUL,
        StDiv  = CODE_MDU_ST_DIV,
        StFix  = CODE_MDU_ST_FIX,
        StDone = CODE_MDU_ST_DONE
    } mdu_state_e;

    // Counts leading zeros within the low 'width' bits of value.
    function automatic int unsigned lead_zeros(input logic [63:0] value, input int unsigned width);
        int unsigned n;
        logic        seen;
        n    = 0;
        seen = 1'b0;
        for (int i = 63; i >= 0; i--) begin
            if (i < int'(width)) begin
                if (value[i]) seen = 1'b1;
                else if (!seen) n++;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division step: shift the next dividend bit into the remainder and
// subtract the divisor if it fits, producing one quotient bit.
module mdu_div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    always_comb begin
        shifted = {rem, quo[WIDTH-1]};
        diff    = shifted - {1'b0, divisor};
        // Remainder is always below the divisor, so a non-negative diff fits WIDTH bits.
        if (diff[WIDTH]) begin
            rem_next = shifted[WIDTH-1:0];
            quo_next = {quo[WIDTH-2:0], 1'b0};
        end else begin
            rem_next = diff[WIDTH-1:0];
            quo_next = {quo[WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/mdu_unit.sv
// Iterative multiply/divide unit owning HI/LO. Define MDU_EARLY_TERM_EN to let
// multiplies and divides finish early (variable latency).
module mdu_unit
    import mdu_unit_pkg::*;
#(
    parameter int unsigned DATA_BUS_WIDTH      = 32,
    parameter int unsigned ALU_FUNCT_BUS_WIDTH = 6
) (
    input  logic                           i_clk,
    input  logic                           i_reset,
    input  logic                           i_flush,
    input  logic                           i_start,
    input  logic [ALU_FUNCT_BUS_WIDTH-1:0] i_funct,
    input  logic [DATA_BUS_WIDTH-1:0]      i_op_a,
    input  logic [DATA_BUS_WIDTH-1:0]      i_op_b,
    output logic                           o_busy,
    output logic                           o_done,
    output logic [DATA_BUS_WIDTH-1:0]      o_hi,
    output logic [DATA_BUS_WIDTH-1:0]      o_lo
);

    localparam int unsigned N    = DATA_BUS_WIDTH;
    localparam int unsigned CntW = $clog2(N) + 1;
    typedef logic [ALU_FUNCT_BUS_WIDTH-1:0] funct_t;

    mdu_state_e      state_q, state_d;
    logic [2*N-1:0]  acc_q, acc_d;
    logic [N-1:0]    mcand_q, mcand_d;
    logic [CntW-1:0] cnt_q, cnt_d, cnt_dec;
    logic [N-1:0]    hi_q, hi_d, lo_q, lo_d;
    logic            neg_res_q, neg_res_d, neg_rem_q, neg_rem_d;
    logic            is_div_q, is_div_d, div0_q, div0_d, done_q, done_d;

    logic is_mult, is_multu, is_div, is_divu, is_mthi, is_mtlo;
    logic is_mul_op, is_div_op, signed_op;
    logic [N-1:0]    a_abs, b_abs, step_rem, step_quo, quo_fix, rem_fix, rem_mask;
    logic [N:0]      mul_sum;
    logic [2*N-1:0]  mul_next, prod, prod_fix;
    int unsigned     lz;

    assign is_mult   = i_funct == funct_t'(CODE_FUNCT_MULT);
    assign is_multu  = i_funct == funct_t'(CODE_FUNCT_MULTU);
    assign is_div    = i_funct == funct_t'(CODE_FUNCT_DIV);
    assign is_divu   = i_funct == funct_t'(CODE_FUNCT_DIVU);
    assign is_mthi   = i_funct == funct_t'(CODE_FUNCT_MTHI);
    assign is_mtlo   = i_funct == funct_t'(CODE_FUNCT_MTLO);
    assign is_mul_op = is_mult | is_multu;
    assign is_div_op = is_div | is_divu;
    assign signed_op = is_mult | is_div;
    // Magnitudes stay unsigned, so |most-negative| is representable.
    assign a_abs = (signed_op & i_op_a[N-1]) ? -i_op_a : i_op_a;
    assign b_abs = (signed_op & i_op_b[N-1]) ? -i_op_b : i_op_b;

    // Shift-add: add the multiplicand into the upper half when the multiplier LSB is set.
    assign mul_sum  = {1'b0, acc_q[2*N-1:N]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    assign mul_next = {mul_sum, acc_q[N-1:1]};
    assign cnt_dec  = cnt_q - 1'b1;
    assign rem_mask = ~({N{1'b1}} << cnt_dec);

    mdu_div_step #(
        .WIDTH(N)
    ) u_div_step (
        .rem     (acc_q[2*N-1:N]),
        .quo     (acc_q[N-1:0]),
        .divisor (mcand_q),
        .rem_next(step_rem),
        .quo_next(step_quo)
    );

    always_comb begin
        prod = acc_q;
`ifdef MDU_EARLY_TERM_EN
        // An early exit leaves the product cnt_q bits short of its final alignment.
        prod = acc_q >> cnt_q;
`endif
        prod_fix = neg_res_q ? -prod : prod;
        quo_fix  = neg_res_q ? -acc_q[N-1:0] : acc_q[N-1:0];
        rem_fix  = neg_rem_q ? -acc_q[2*N-1:N] : acc_q[2*N-1:N];
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        is_div_d  = is_div_q;
        div0_d    = div0_q;
        done_d    = 1'b0;
        lz        = 0;
        unique case (state_q)
            StIdle: begin
                if (i_start && !i_flush) begin
                    if (is_mthi) begin
                        hi_d   = i_op_a;
                        done_d = 1'b1;
                    end else if (is_mtlo) begin
                        lo_d   = i_op_a;
                        done_d = 1'b1;
                    end else if (is_mul_op || is_div_op) begin
                        neg_res_d = signed_op & (i_op_a[N-1] ^ i_op_b[N-1]);
                        neg_rem_d = signed_op & i_op_a[N-1];
                        is_div_d  = is_div_op;
                        div0_d    = 1'b0;
                        cnt_d     = CntW'(N);
                        if (is_div_op && i_op_b == '0) begin
                            acc_d   = {i_op_a, {N{1'b1}}};
                            div0_d  = 1'b1;
                            state_d = StFix;
                        end else if (is_mul_op) begin
                            acc_d   = {{N{1'b0}}, b_abs};
                            mcand_d = a_abs;
                            state_d = StMul;
                        end else begin
                            mcand_d = b_abs;
`ifdef MDU_EARLY_TERM_EN
                            lz = lead_zeros(64'(a_abs), N);
                            if (lz > N - 1) lz = N - 1;
                            acc_d = {{N{1'b0}}, a_abs << lz};
                            cnt_d = CntW'(N - lz);
`else
                            acc_d = {{N{1'b0}}, a_abs};
`endif
                            state_d = StDiv;
                        end
                    end
                end
            end
            StMul: begin
                acc_d = mul_next;
                cnt_d = cnt_dec;
                if (cnt_q == CntW'(1)) state_d = StFix;
`ifdef MDU_EARLY_TERM_EN
                if ((mul_next[N-1:0] & rem_mask) == '0) state_d = StFix;
`endif
            end
            StDiv: begin
                acc_d = {step_rem, step_quo};
                cnt_d = cnt_dec;
                if (cnt_q == CntW'(1)) state_d = StFix;
            end
            StFix: begin
                if (div0_q) begin
                    hi_d = acc_q[2*N-1:N];
                    lo_d = acc_q[N-1:0];
                end else if (is_div_q) begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end else begin
                    hi_d = prod_fix[2*N-1:N];
                    lo_d = prod_fix[N-1:0];
                end
                done_d  = 1'b1;
                state_d = StDone;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        // Flush abandons any in-flight op; a write already made in DONE is kept.
        if (i_flush && state_q != StIdle) begin
            state_d = StIdle;
            done_d  = 1'b0;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q   <= StIdle;
            acc_q     <= '0;
            mcand_q   <= '0;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            is_div_q  <= 1'b0;
            div0_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            is_div_q  <= is_div_d;
            div0_q    <= div0_d;
            done_q    <= done_d;
        end
    end

    assign o_busy = (state_q == StMul) || (state_q == StDiv) || (state_q == StFix);
    assign o_done = done_q;
    assign o_hi   = hi_q;
    assign o_lo   = lo_q;

endmodule
